// File: rtl/mt_fetch_pkg.sv
// Shared types and helpers for the multi-threaded fetch unit.
// Pure declarations: no logic, no latency.
// No flow control.
package mt_fetch_pkg;

  localparam int MAX_TID_W  = 8;
  localparam int MAX_ADDR_W = 64;

  // One fetch slot: address, owning thread, and whether it is live.
  typedef struct packed {
    logic                  vld;
    logic [MAX_TID_W-1:0]  tid;
    logic [MAX_ADDR_W-1:0] pc;
  } thread_pc_t;

  // Thread-id width; a single-thread build still carries one tid bit.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

  // Reset PC of a thread: its tid in the top bits, zero offset.
  function automatic logic [MAX_ADDR_W-1:0] reset_pc(input int tid, input int addr_w, input int tid_w);
    return MAX_ADDR_W'(tid) << (addr_w - tid_w);
  endfunction

endpackage

// File: rtl/rr_thread_arbiter.sv
// Round-robin thread picker: first enabled thread after the last grant, last grant itself checked last.
// Purely combinational, zero latency.
// i_hold suppresses any new grant; the last grant is echoed with o_grant_vld low.
module rr_thread_arbiter
  import mt_fetch_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int TID_W       = tid_width(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] i_en,
  input  logic [TID_W-1:0]       i_last,
  input  logic                   i_hold,
  output logic [TID_W-1:0]       o_grant,
  output logic                   o_grant_vld
);

  logic [TID_W-1:0] w_idx;
  logic             w_found;

  // Walk the ring starting just after the last grant; the first enabled thread wins.
  always_comb begin
    o_grant     = i_last;
    o_grant_vld = 1'b0;
    w_found     = 1'b0;
    w_idx       = i_last;
    for (int k = 0; k < NUM_THREADS; k++) begin
      w_idx = (w_idx == TID_W'(NUM_THREADS - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && !i_hold && i_en[w_idx]) begin
        w_found = 1'b1;
        o_grant = w_idx;
      end
    end
    o_grant_vld = w_found;
  end

endmodule

// File: rtl/mt_fetch_unit.sv
// Barrel fetch unit: per-thread PCs, round-robin thread select, combinational next PC to the i_cache.
// o_*_next is combinational (zero latency from inputs); o_*_current follows one clock later.
// i_stall freezes selection and the current fetch; redirects still land and squash a stalled fetch.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 26
`endif

module mt_fetch_unit
  import mt_fetch_pkg::*;
#(
  parameter int NUM_THREADS = 2,
  parameter int ADDR_WIDTH  = `ADDR_WIDTH,
  parameter int TID_W       = tid_width(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_THREADS-1:0] i_thread_en,
  input  logic                   i_stall,
  input  logic                   i_load_we,
  input  logic [TID_W-1:0]       i_load_tid,
  input  logic [ADDR_WIDTH-1:0]  i_load_pc,
  input  logic                   i_bp_is_branch,
  input  logic                   i_bp_taken,
  input  logic [ADDR_WIDTH-1:0]  i_bp_target,
  output logic [ADDR_WIDTH-1:0]  o_pc_current,
  output logic [TID_W-1:0]       o_tid_current,
  output logic                   o_valid_current,
  output logic [ADDR_WIDTH-1:0]  o_pc_next,
  output logic [TID_W-1:0]       o_tid_next,
  output logic                   o_valid_next
);

  // Low bits of every PC are the per-thread offset; the top TID_W bits are the owner.
  localparam int OFF_W = ADDR_WIDTH - TID_W;

  function automatic logic [ADDR_WIDTH-1:0] force_tid(input logic [TID_W-1:0] tid,
                                                      input logic [OFF_W-1:0] off);
    return {tid, off};
  endfunction

  logic [ADDR_WIDTH-1:0] r_pc_q [NUM_THREADS];
  logic [TID_W-1:0]      r_rr_q;
  logic [ADDR_WIDTH-1:0] r_cur_pc;
  logic [TID_W-1:0]      r_cur_tid;
  logic                  r_cur_valid;
  logic                  r_kill_q;

  logic [ADDR_WIDTH-1:0] w_rst_pc [NUM_THREADS];
  logic [TID_W-1:0]      w_sel;
  logic                  w_sel_vld;
  logic                  w_advance;
  logic [OFF_W-1:0]      w_adv_off;
  logic [ADDR_WIDTH-1:0] w_adv_pc;
  logic [ADDR_WIDTH-1:0] w_load_pc;
  logic                  w_load_hits_cur;
  logic                  w_unused;

  // Reset PC table, one {tid, 0} per thread.
  for (genvar g = 0; g < NUM_THREADS; g++) begin : g_rst_pc
    localparam logic [MAX_ADDR_W-1:0] RST_PC = reset_pc(g, ADDR_WIDTH, TID_W);
    assign w_rst_pc[g] = RST_PC[ADDR_WIDTH-1:0];
  end

  // Upper bits of redirect and target addresses are replaced by the owning tid.
  assign w_unused = ^{i_load_pc[ADDR_WIDTH-1:OFF_W], i_bp_target[ADDR_WIDTH-1:OFF_W]};

  rr_thread_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_arb (
    .i_en        (i_thread_en),
    .i_last      (r_rr_q),
    .i_hold      (i_stall),
    .o_grant     (w_sel),
    .o_grant_vld (w_sel_vld)
  );

  // The in-flight fetch retires this cycle unless stalled or squashed by an earlier redirect.
  assign w_advance       = ~i_stall & r_cur_valid & ~r_kill_q;
  assign w_adv_off       = (i_bp_is_branch & i_bp_taken) ? i_bp_target[OFF_W-1:0]
                                                         : (r_cur_pc[OFF_W-1:0] + OFF_W'(4));
  assign w_adv_pc        = force_tid(r_cur_tid, w_adv_off);
  assign w_load_pc       = force_tid(i_load_tid, i_load_pc[OFF_W-1:0]);
  assign w_load_hits_cur = i_load_we & (i_load_tid == r_cur_tid);

  // Next fetch address: write-through of this cycle's PC updates so a lone thread
  // fetches every cycle and a redirect is visible without waiting for pc_q.
  always_comb begin
    o_pc_next    = r_cur_pc;
    o_tid_next   = r_cur_tid;
    o_valid_next = 1'b0;
    if (i_stall) begin
      o_valid_next = r_cur_valid;
    end else if (w_sel_vld) begin
      o_tid_next   = w_sel;
      o_valid_next = 1'b1;
      if (i_load_we && (i_load_tid == w_sel)) begin
        o_pc_next = w_load_pc;
      end else if (w_advance && (r_cur_tid == w_sel)) begin
        o_pc_next = w_adv_pc;
      end else begin
        o_pc_next = r_pc_q[w_sel];
      end
    end
  end

  // Per-thread PCs: advance the retiring fetch, then let a redirect override it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_pc_q[t] <= w_rst_pc[t];
      end
    end else begin
      if (w_advance) begin
        r_pc_q[r_cur_tid] <= w_adv_pc;
      end
      if (i_load_we) begin
        r_pc_q[i_load_tid] <= w_load_pc;
      end
    end
  end

  // Current fetch register, arbiter history and stall-time squash flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_pc    <= '0;
      r_cur_tid   <= '0;
      r_cur_valid <= 1'b0;
      r_kill_q    <= 1'b0;
      r_rr_q      <= TID_W'(NUM_THREADS - 1);
    end else if (!i_stall) begin
      r_cur_pc    <= o_pc_next;
      r_cur_tid   <= o_tid_next;
      r_cur_valid <= o_valid_next;
      r_kill_q    <= 1'b0;
      if (w_sel_vld) begin
        r_rr_q <= w_sel;
      end
    end else if (w_load_hits_cur) begin
      r_kill_q <= 1'b1;
    end
  end

  assign o_pc_current    = r_cur_pc;
  assign o_tid_current   = r_cur_tid;
  assign o_valid_current = r_cur_valid & ~r_kill_q;

endmodule
